// File: rtl/sdram_frame_reader_if.sv
// sdram_frame_reader_if: controller, FIFO and control signals of the SDRAM frame reader.
// buffer_select exists only when SDRAM_FRAME_READER_DOUBLE_BUFFER_EN is defined.
interface sdram_frame_reader_if #(
  parameter int ADDR_WIDTH         = 22,
  parameter int DATA_WIDTH         = 16,
  parameter int FIFO_POINTER_WIDTH = 5
);
  logic                          enable;
  logic [1:0]                    command;
  logic [ADDR_WIDTH-1:0]         data_address;
  logic [DATA_WIDTH-1:0]         data_read;
  logic                          data_read_valid;
  logic [FIFO_POINTER_WIDTH-1:0] fifo_used;
  logic [DATA_WIDTH-1:0]         fifo_data;
  logic                          fifo_data_enable;
  logic                          first_data_ready;
  logic                          frame_start;
`ifdef SDRAM_FRAME_READER_DOUBLE_BUFFER_EN
  logic                          buffer_select;
`endif
  modport master (
    input  enable, data_read, data_read_valid, fifo_used,
`ifdef SDRAM_FRAME_READER_DOUBLE_BUFFER_EN
    input  buffer_select,
`endif
    output command, data_address, fifo_data, fifo_data_enable, first_data_ready, frame_start
  );
  modport slave (
    output enable, data_read, data_read_valid, fifo_used,
`ifdef SDRAM_FRAME_READER_DOUBLE_BUFFER_EN
    output buffer_select,
`endif
    input  command, data_address, fifo_data, fifo_data_enable, first_data_ready, frame_start
  );
endinterface

// File: rtl/sdram_frame_reader.sv
// sdram_frame_reader: streams a linear framebuffer from SDRAM into the pixel FIFO in fixed bursts.
// SDRAM_FRAME_READER_DOUBLE_BUFFER_EN adds buffer_select to pick the frame base at reset and each wrap.
module sdram_frame_reader #(
  parameter int ADDR_WIDTH         = 22,
  parameter int DATA_WIDTH         = 16,
  parameter int BURST_LENGTH       = 8,
  parameter int FRAME_WORDS        = 307200,
  parameter int BASE_ADDRESS       = 0,
  parameter int FIFO_POINTER_WIDTH = 5,
  parameter int FIFO_HIGH_WATER    = 24
) (
  input logic clk,
  input logic reset,
  sdram_frame_reader_if.master bus
);
  localparam int CW = BURST_LENGTH > 1 ? $clog2(BURST_LENGTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] BASE = ADDR_WIDTH'(BASE_ADDRESS);
  localparam logic [ADDR_WIDTH-1:0] FW = ADDR_WIDTH'(FRAME_WORDS);
  localparam logic [31:0] THRESH = 32'(FIFO_HIGH_WATER - BURST_LENGTH);
  if (FRAME_WORDS % BURST_LENGTH != 0) begin : g_bad_frame
    $error("FRAME_WORDS must be a multiple of BURST_LENGTH");
  end
  typedef enum logic {IDLE, BURST} state_t;
  state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d, base_q, base_d, sel_base, last_addr;
  logic fs_q, fs_d, rdy_q, rdy_d;
  logic push, wrap, issue, done;
  logic [DATA_WIDTH-1:0] data_w;
`ifdef SDRAM_FRAME_READER_DOUBLE_BUFFER_EN
  assign sel_base = bus.buffer_select ? BASE + FW : BASE;
`else
  assign sel_base = BASE;
`endif
  assign last_addr = base_q + FW - ADDR_WIDTH'(1);
  assign push = state_q == BURST && bus.data_read_valid;
  assign wrap = addr_q == last_addr;
  assign issue = bus.enable && {{(32-FIFO_POINTER_WIDTH){1'b0}}, bus.fifo_used} <= THRESH;
  assign done = push && cnt_q == '0;
  always_comb begin
    state_d = state_q == IDLE ? (issue ? BURST : IDLE) : (done ? IDLE : BURST);
    cnt_d = state_q == IDLE ? CW'(BURST_LENGTH - 1) : (push ? cnt_q - CW'(1) : cnt_q);
    addr_d = push ? (wrap ? sel_base : addr_q + ADDR_WIDTH'(1)) : addr_q;
    base_d = push && wrap ? sel_base : base_q;
    fs_d = push && wrap;
    rdy_d = rdy_q | done;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      addr_q <= sel_base;
      base_q <= sel_base;
      fs_q <= 1'b0;
      rdy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      addr_q <= addr_d;
      base_q <= base_d;
      fs_q <= fs_d;
      rdy_q <= rdy_d;
    end
  end
  // command is a decode of the registered state, so it rises one cycle after issue
  assign bus.command = state_q == BURST ? 2'd2 : 2'd0;
  assign bus.data_address = addr_q;
  assign data_w = bus.data_read;
  assign bus.fifo_data = data_w;
  assign bus.fifo_data_enable = push;
  assign bus.first_data_ready = rdy_q;
  assign bus.frame_start = fs_q;
endmodule
